lock_controller: RTL
====================

# lock_controller

Code-entry state machine for the digital lock, sitting directly downstream of the four per-button edge detectors. It consumes their one-cycle press pulses as digits, compares the entered sequence against a stored code, and drives the locked/unlocked/lockout indications. While unlocked, it also lets the user program a new code.

## Interface
- CODE_LENGTH, 4: digits per code; range 1–7.
- MAX_ATTEMPTS, 3: consecutive failed entries that trigger lockout; range 1–15.
- LOCKOUT_CYCLES, 50_000_000: clock cycles spent in lockout; must be ≥1.
- DEFAULT_CODE, 8'hE4: code loaded at reset, 2 bits per digit, digit 0 (entered first) in the LSBs. Width is 2*CODE_LENGTH. The default value encodes the digits 0,1,2,3.
- clock  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- buttonEdge  input  4  one-cycle press pulses; bit i means digit i.
- locked  output  1  high in LOCKED, ENTRY and LOCKOUT.
- unlocked  output  1  high in UNLOCKED and NEW_CODE.
- lockout  output  1  high in LOCKOUT only.
- error  output  1  one-cycle pulse on a failed entry or an aborted code change.
- digitCount  output  3  number of digits accepted in the current entry or new-code sequence.

## Operation
- All outputs are registered.
- Reset values:
  - locked=1, unlocked=0, lockout=0, error=0, digitCount=0.
  - State is LOCKED, failCount=0, mismatch=0.
  - Code register is loaded with DEFAULT_CODE.
- Reset asserted mid-sequence aborts the sequence. Any programmed code is replaced by DEFAULT_CODE.
- Valid press: exactly one bit of buttonEdge is high. Multi-press: two or more bits are high. Zero bits high means no event.
- LOCKED:
  - A valid press or a multi-press moves to ENTRY and is counted as digit 0.
- ENTRY:
  - Each press increments digitCount.
  - A valid press whose index differs from the stored digit at position digitCount sets the sticky mismatch flag.
  - A multi-press always sets mismatch.
  - On the press that brings digitCount to CODE_LENGTH:
    - If mismatch is 0, go to UNLOCKED and clear failCount.
    - If mismatch is 1, pulse error and increment failCount. If the new failCount equals MAX_ATTEMPTS, go to LOCKOUT; otherwise go to LOCKED.
  - In every case digitCount and mismatch clear on that same edge.
- LOCKOUT:
  - All buttonEdge activity is ignored.
  - A down-counter loaded with LOCKOUT_CYCLES-1 on entry decrements each cycle.
  - When the counter reaches 0, go to LOCKED and clear failCount.
- UNLOCKED:
  - A valid press on bit 0 relocks (go to LOCKED).
  - A valid press on bit 3 goes to NEW_CODE; that press is not stored as a digit.
  - Bits 1 and 2, and any multi-press, are ignored.
- NEW_CODE:
  - Each valid press shifts its index into a shadow register at position digitCount and increments digitCount.
  - On the CODE_LENGTH-th digit, copy the shadow register into the code register and return to UNLOCKED. The new code is used from the next entry onward.
  - A multi-press aborts the change: pulse error, discard the shadow register, clear digitCount, return to UNLOCKED. The code register is unchanged.
- failCount persists across LOCKED↔ENTRY cycles. It clears only on a successful unlock, at lockout expiry, or on reset.

## Timing
- A press sampled at edge N updates state and all outputs at edge N; the change is visible during cycle N+1.
- Final correct digit at edge N: unlocked=1 and locked=0 from cycle N+1.
- error is high for exactly one cycle, in the cycle after the failing or aborting press.
- Lockout entered at edge N: lockout is high for exactly LOCKOUT_CYCLES cycles, then locked=1 with lockout=0.
- Presses may arrive on back-to-back cycles. No press is dropped outside LOCKOUT.
- Presses arriving in the same cycle as a state exit are consumed by the exiting state only.

## Test plan
- Reset, then pulses 0,1,2,3 on consecutive cycles: digitCount steps 1,2,3, then unlocked=1 one cycle after the 4th pulse with digitCount=0.
- Wrong entry: presses 0,1,2,2 give a single error pulse, then locked=1 with failCount=1. Next, a correct entry unlocks and failCount clears to 0.
- Lockout, with LOCKOUT_CYCLES=8: three wrong entries give lockout=1 for exactly 8 cycles. Presses during lockout are ignored. Then locked=1 and a correct code unlocks.
- Multi-press: buttonEdge=4'b0011 as the 2nd digit of otherwise-correct 0,x,2,3 causes failure and an error pulse. In NEW_CODE, the same multi-press aborts, and the old code still unlocks.
- Code change: from UNLOCKED, press 3 then digits 3,3,1,0, then press 0 to relock. Entry 0,1,2,3 now fails; entry 3,3,1,0 unlocks.
- Reset mid-entry after 2 digits: all outputs return to reset values and the code returns to DEFAULT_CODE. A subsequent 0,1,2,3 entry unlocks.

Source files
------------

// File: rtl/lock_controller.sv
`default_nettype none
// ============================================================================
// Module   : lock_controller
// Brief    : Digit-entry state machine for the digital lock: code compare,
//            failed-attempt lockout and new-code programming while unlocked.
// Revision : 1.0 - initial release
// ============================================================================
module lock_controller #(
    parameter int                         CODE_LENGTH    = 4,
    parameter int                         MAX_ATTEMPTS   = 3,
    parameter int                         LOCKOUT_CYCLES = 50_000_000,
    parameter logic [2*CODE_LENGTH-1:0]   DEFAULT_CODE   = 8'hE4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] buttonEdge,
    output logic       locked,
    output logic       unlocked,
    output logic       lockout,
    output logic       error,
    output logic [2:0] digitCount
);

    localparam int                  c_LOCK_W    = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [c_LOCK_W-1:0] c_LOCK_LOAD = c_LOCK_W'(LOCKOUT_CYCLES - 1);
    localparam logic [2:0]          c_CODE_LEN  = 3'(CODE_LENGTH);
    localparam logic [3:0]          c_MAX_ATT   = 4'(MAX_ATTEMPTS);

    localparam logic [2:0] S_LOCKED   = 3'd0;
    localparam logic [2:0] S_ENTRY    = 3'd1;
    localparam logic [2:0] S_UNLOCKED = 3'd2;
    localparam logic [2:0] S_NEW_CODE = 3'd3;
    localparam logic [2:0] S_LOCKOUT  = 3'd4;

    logic [2:0]               r_state,    w_state_nx;
    logic [3:0]               r_fail,     w_fail_nx;
    logic                     r_mis,      w_mis_nx;
    logic [2:0]               r_cnt,      w_cnt_nx;
    logic [2*CODE_LENGTH-1:0] r_code,     w_code_nx;
    logic [2*CODE_LENGTH-1:0] r_shadow,   w_shadow_nx;
    logic [c_LOCK_W-1:0]      r_lock_cnt, w_lock_cnt_nx;
    logic                     w_error_nx;
    logic                     r_locked, r_unlocked, r_lockout, r_error;

    logic                     w_press, w_valid, w_multi, w_mis_new;
    logic [1:0]               w_index, w_stored;
    logic [2:0]               w_cnt_inc;
    logic [3:0]               w_fail_inc;
    logic [2*CODE_LENGTH-1:0] w_shadow_ins;

    always_comb begin
        w_press    = |buttonEdge;
        w_valid    = w_press && ((buttonEdge & (buttonEdge - 4'd1)) == 4'd0);
        w_multi    = w_press && !w_valid;
        w_cnt_inc  = r_cnt + 3'd1;
        w_fail_inc = r_fail + 4'd1;
        case (buttonEdge)
            4'b0010: w_index = 2'd1;
            4'b0100: w_index = 2'd2;
            4'b1000: w_index = 2'd3;
            default: w_index = 2'd0;
        endcase
        // Constant-index loops avoid variable part-selects on the code words
        w_stored     = 2'd0;
        w_shadow_ins = r_shadow;
        for (int i = 0; i < CODE_LENGTH; i++) begin
            if (r_cnt == 3'(i)) begin
                w_stored              = r_code[2*i +: 2];
                w_shadow_ins[2*i +: 2] = w_index;
            end
        end
        w_mis_new = r_mis || w_multi || (w_index != w_stored);
    end

    always_comb begin
        w_state_nx    = r_state;
        w_fail_nx     = r_fail;
        w_mis_nx      = r_mis;
        w_cnt_nx      = r_cnt;
        w_code_nx     = r_code;
        w_shadow_nx   = r_shadow;
        w_lock_cnt_nx = r_lock_cnt;
        w_error_nx    = 1'b0;
        case (r_state)
            S_LOCKED, S_ENTRY: begin
                if (w_press) begin
                    if (w_cnt_inc == c_CODE_LEN) begin
                        w_cnt_nx = 3'd0;
                        w_mis_nx = 1'b0;
                        if (!w_mis_new) begin
                            w_state_nx = S_UNLOCKED;
                            w_fail_nx  = 4'd0;
                        end else begin
                            w_error_nx = 1'b1;
                            w_fail_nx  = w_fail_inc;
                            if (w_fail_inc == c_MAX_ATT) begin
                                w_state_nx    = S_LOCKOUT;
                                w_lock_cnt_nx = c_LOCK_LOAD;
                            end else begin
                                w_state_nx = S_LOCKED;
                            end
                        end
                    end else begin
                        w_cnt_nx   = w_cnt_inc;
                        w_mis_nx   = w_mis_new;
                        w_state_nx = S_ENTRY;
                    end
                end
            end
            S_LOCKOUT: begin
                if (r_lock_cnt == '0) begin
                    w_state_nx = S_LOCKED;
                    w_fail_nx  = 4'd0;
                end else begin
                    w_lock_cnt_nx = r_lock_cnt - 1'b1;
                end
            end
            S_UNLOCKED: begin
                if (w_valid && buttonEdge[0]) begin
                    w_state_nx = S_LOCKED;
                end else if (w_valid && buttonEdge[3]) begin
                    w_state_nx  = S_NEW_CODE;
                    w_shadow_nx = '0;
                    w_cnt_nx    = 3'd0;
                end
            end
            S_NEW_CODE: begin
                if (w_multi) begin
                    w_error_nx  = 1'b1;
                    w_shadow_nx = '0;
                    w_cnt_nx    = 3'd0;
                    w_state_nx  = S_UNLOCKED;
                end else if (w_valid) begin
                    if (w_cnt_inc == c_CODE_LEN) begin
                        w_code_nx   = w_shadow_ins;
                        w_shadow_nx = '0;
                        w_cnt_nx    = 3'd0;
                        w_state_nx  = S_UNLOCKED;
                    end else begin
                        w_shadow_nx = w_shadow_ins;
                        w_cnt_nx    = w_cnt_inc;
                    end
                end
            end
            default: w_state_nx = S_LOCKED;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_LOCKED;
            r_fail     <= 4'd0;
            r_mis      <= 1'b0;
            r_cnt      <= 3'd0;
            r_code     <= DEFAULT_CODE;
            r_shadow   <= '0;
            r_lock_cnt <= '0;
            r_error    <= 1'b0;
            r_locked   <= 1'b1;
            r_unlocked <= 1'b0;
            r_lockout  <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_fail     <= w_fail_nx;
            r_mis      <= w_mis_nx;
            r_cnt      <= w_cnt_nx;
            r_code     <= w_code_nx;
            r_shadow   <= w_shadow_nx;
            r_lock_cnt <= w_lock_cnt_nx;
            r_error    <= w_error_nx;
            r_locked   <= (w_state_nx == S_LOCKED) || (w_state_nx == S_ENTRY) ||
                          (w_state_nx == S_LOCKOUT);
            r_unlocked <= (w_state_nx == S_UNLOCKED) || (w_state_nx == S_NEW_CODE);
            r_lockout  <= (w_state_nx == S_LOCKOUT);
        end
    end

    assign locked     = r_locked;
    assign unlocked   = r_unlocked;
    assign lockout    = r_lockout;
    assign error      = r_error;
    assign digitCount = r_cnt;

endmodule
`default_nettype wire
